warmboot_ctrl: RTL and testbench



---
 rtl/warmboot_ctrl.sv | 161 ++++++++++++++++
 tb/tb_warmboot_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/warmboot_ctrl.sv
// Warm-boot controller placed directly upstream of SB_WARMBOOT.
// A boot request comes from the debounced push-button or from the
// valid/ready port. A cancellable grace countdown blinks LED_IND, then
// BOOT is asserted and held until reset.
module warmboot_ctrl #(
  parameter int         DEBOUNCE_LOG2 = 16,
  parameter int         GRACE_LOG2    = 22,
  parameter int         GRACE_TICKS   = 15,
  parameter logic [1:0] DEFAULT_IMAGE = 2'b11
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       BTN,
  input  logic       REQ_VALID,
  input  logic [1:0] REQ_IMAGE,
  output logic       REQ_READY,
  input  logic       CANCEL,
  output logic       BOOT,
  output logic       S1,
  output logic       S0,
  output logic       BUSY,
  output logic       LED_IND
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ARMED = 2'd1,
    ST_FIRE  = 2'd2
  } state_t;

  localparam logic [DEBOUNCE_LOG2-1:0] DEB_MAX    = '1;
  localparam logic [GRACE_LOG2-1:0]    PRESC_MAX  = '1;
  localparam logic [3:0]               TICKS_LAST = 4'(GRACE_TICKS);

  state_t                   state_q, state_d;
  logic [1:0]               sync_q, sync_d;
  logic [DEBOUNCE_LOG2-1:0] deb_cnt_q, deb_cnt_d;
  logic                     deb_lvl_q, deb_lvl_d;
  logic                     btn_evt_q, btn_evt_d;
  logic [GRACE_LOG2-1:0]    presc_q, presc_d;
  logic [3:0]               tick_cnt_q, tick_cnt_d;
  logic [1:0]               image_q, image_d;
  logic                     boot_q, boot_d;
  logic                     ready_q, ready_d;
  logic                     busy_q, busy_d;
  logic                     led_q, led_d;
  logic                     tick;

  // Button path: two-stage synchronizer feeding a saturating debounce counter.
  // The counter only advances while the synchronized level disagrees with the
  // debounced level; btn_evt fires once on a debounced rising edge.
  always_comb begin
    sync_d    = {sync_q[0], BTN};
    deb_cnt_d = deb_cnt_q;
    deb_lvl_d = deb_lvl_q;
    if (sync_q[1] == deb_lvl_q) begin
      deb_cnt_d = '0;
    end else if (deb_cnt_q == DEB_MAX) begin
      deb_lvl_d = sync_q[1];
    end else begin
      deb_cnt_d = deb_cnt_q + 1'b1;
    end
    btn_evt_d = deb_lvl_d & ~deb_lvl_q;
  end

  // Control FSM: request acceptance, grace countdown with blink, and firing.
  always_comb begin
    tick       = (presc_q == PRESC_MAX);
    state_d    = state_q;
    presc_d    = presc_q;
    tick_cnt_d = tick_cnt_q;
    image_d    = image_q;
    boot_d     = boot_q;
    led_d      = led_q;
    case (state_q)
      ST_IDLE: begin
        presc_d    = '0;
        tick_cnt_d = '0;
        led_d      = 1'b0;
        boot_d     = 1'b0;
        // A port request outranks a coinciding button event, which is lost.
        if (REQ_VALID && ready_q) begin
          image_d = REQ_IMAGE;
          state_d = ST_ARMED;
        end else if (btn_evt_q) begin
          image_d = DEFAULT_IMAGE;
          state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        // Abort takes precedence over a final tick landing on the same edge.
        if (CANCEL || btn_evt_q) begin
          state_d    = ST_IDLE;
          led_d      = 1'b0;
          image_d    = DEFAULT_IMAGE;
          presc_d    = '0;
          tick_cnt_d = '0;
        end else begin
          presc_d = presc_q + 1'b1;
          if (tick) begin
            led_d      = ~led_q;
            tick_cnt_d = tick_cnt_q + 1'b1;
            if ((tick_cnt_q + 4'd1) == TICKS_LAST) begin
              state_d = ST_FIRE;
              boot_d  = 1'b1;
              led_d   = 1'b1;
            end
          end
        end
      end
      ST_FIRE: begin
        boot_d = 1'b1;
        led_d  = 1'b1;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
  end

  // State and output registers; reset returns everything to the idle image.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= ST_IDLE;
      sync_q     <= '0;
      deb_cnt_q  <= '0;
      deb_lvl_q  <= 1'b0;
      btn_evt_q  <= 1'b0;
      presc_q    <= '0;
      tick_cnt_q <= '0;
      image_q    <= DEFAULT_IMAGE;
      boot_q     <= 1'b0;
      ready_q    <= 1'b0;
      busy_q     <= 1'b0;
      led_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      sync_q     <= sync_d;
      deb_cnt_q  <= deb_cnt_d;
      deb_lvl_q  <= deb_lvl_d;
      btn_evt_q  <= btn_evt_d;
      presc_q    <= presc_d;
      tick_cnt_q <= tick_cnt_d;
      image_q    <= image_d;
      boot_q     <= boot_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      led_q      <= led_d;
    end
  end

  assign BOOT      = boot_q;
  assign S1        = image_q[1];
  assign S0        = image_q[0];
  assign REQ_READY = ready_q;
  assign BUSY      = busy_q;
  assign LED_IND   = led_q;

endmodule

// File: tb/tb_warmboot_ctrl.sv
// Bench for warmboot_ctrl with short debounce/grace settings.
module tb_warmboot_ctrl;

  logic       CLK = 1'b0;
  logic       RST;
  logic       BTN;
  logic       REQ_VALID;
  logic [1:0] REQ_IMAGE;
  logic       REQ_READY;
  logic       CANCEL;
  logic       BOOT;
  logic       S1;
  logic       S0;
  logic       BUSY;
  logic       LED_IND;

  warmboot_ctrl #(
    .DEBOUNCE_LOG2(2),
    .GRACE_LOG2   (3),
    .GRACE_TICKS  (3),
    .DEFAULT_IMAGE(2'b11)
  ) dut (
    .CLK      (CLK),
    .RST      (RST),
    .BTN      (BTN),
    .REQ_VALID(REQ_VALID),
    .REQ_IMAGE(REQ_IMAGE),
    .REQ_READY(REQ_READY),
    .CANCEL   (CANCEL),
    .BOOT     (BOOT),
    .S1       (S1),
    .S0       (S0),
    .BUSY     (BUSY),
    .LED_IND  (LED_IND)
  );

  always #5 CLK = ~CLK;

  // Edge counter: at a falling edge, cyc equals the number of rising edges so far.
  int cyc = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  // Grace period in cycles: GRACE_TICKS * 2^GRACE_LOG2 = 3 * 8.
  localparam int GRACE = 24;
  localparam int TICK  = 8;
  // Button press sampled at edge k+1 is accepted at edge k+7
  // (2 sync stages, 4 stable samples, 1 event register).
  localparam int BTN_LAT = 7;

  // Output vector order: {BOOT, S1, S0, REQ_READY, BUSY, LED_IND}
  localparam logic [5:0] RESET_V = 6'b011000;
  localparam logic [5:0] IDLE_V  = 6'b011100;
  wire [5:0] outs = {BOOT, S1, S0, REQ_READY, BUSY, LED_IND};

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    logic [1:0] img;
  } boot_exp_t;
  boot_exp_t exp_q[$];

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every BOOT rising edge must match the next queued expectation.
  initial begin : boot_monitor
    logic      boot_prev;
    boot_exp_t e;
    boot_prev = 1'b0;
    forever begin
      @(negedge CLK);
      if (BOOT && !boot_prev && !RST) begin
        if (exp_q.size() == 0) begin
          check("unexpected_boot", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("boot_cycle", cyc, e.at);
          check("boot_image", {S1, S0}, e.img);
        end
      end
      boot_prev = BOOT;
    end
  end

  task automatic do_reset();
    RST       = 1'b1;
    BTN       = 1'b0;
    REQ_VALID = 1'b0;
    REQ_IMAGE = 2'b00;
    CANCEL    = 1'b0;
    repeat (2) @(negedge CLK);
    check("reset_state", outs, RESET_V);
    RST = 1'b0;
    repeat (2) @(negedge CLK);
    check("post_reset_idle", outs, IDLE_V);
  endtask

  // One scenario starting from idle. Offsets are in cycles relative to the
  // starting falling edge (stimulus) or the accepting edge (cancel/reset).
  task automatic run_case(input string tag, input bit use_btn, input int blen,
                          input bit use_req, input int req_off, input logic [1:0] img,
                          input int cancel_off, input int rst_off, input bit noise,
                          input int total);
    int         k;
    int         a;
    int         t;
    int         c;
    bit         acc;
    logic [1:0] eimg;
    logic [5:0] e;
    k    = cyc;
    acc  = 1'b0;
    a    = 0;
    eimg = 2'b11;
    if (use_btn && blen >= 4) begin
      acc = 1'b1;
      a   = k + BTN_LAT;
    end
    // Requests are only issued on or before the button's accepting edge;
    // on the same edge the request image wins.
    if (use_req && (!acc || k + req_off + 1 <= a)) begin
      acc  = 1'b1;
      a    = k + req_off + 1;
      eimg = img;
    end
    if (acc && cancel_off == 0 && (rst_off == 0 || rst_off >= GRACE))
      exp_q.push_back('{at: a + GRACE, img: eimg});
    for (int j = 0; j < total; j++) begin
      c = cyc;
      if (!acc || c < a) begin
        e = IDLE_V;
      end else begin
        t = c - a;
        if (cancel_off != 0 && t >= cancel_off) e = IDLE_V;
        else if (t >= GRACE) e = {1'b1, eimg, 1'b0, 1'b1, 1'b1};
        else e = {1'b0, eimg, 1'b0, 1'b1, ((t / TICK) % 2) != 0};
      end
      check(tag, outs, e);
      if (acc && rst_off != 0 && c == a + rst_off) begin
        #2 RST = 1'b1;
        #1 check({tag, "_async_rst"}, outs, RESET_V);
        break;
      end
      BTN       = (use_btn && j < blen);
      REQ_VALID = (use_req && j == req_off);
      REQ_IMAGE = REQ_VALID ? img : 2'($urandom);
      if (!acc || c < a) CANCEL = 1'($urandom % 2);
      else CANCEL = (cancel_off != 0 && c == a + cancel_off - 1);
      if (noise && acc && cancel_off == 0 && c >= a + GRACE + 1) begin
        CANCEL    = 1'($urandom % 2);
        BTN       = 1'($urandom % 2);
        REQ_VALID = 1'($urandom % 2);
      end
      @(negedge CLK);
    end
    BTN       = 1'b0;
    REQ_VALID = 1'b0;
    CANCEL    = 1'b0;
    check({tag, "_queue_drained"}, exp_q.size(), 0);
  endtask

  initial begin : stimulus
    int         kind;
    int         canc;
    logic [1:0] img;
    RST       = 1'b1;
    BTN       = 1'b0;
    REQ_VALID = 1'b0;
    REQ_IMAGE = 2'b00;
    CANCEL    = 1'b0;

    do_reset(); run_case("req01_hold",    0, 0,  1, 0, 2'b01, 0,  0,  0, 125);
    do_reset(); run_case("btn_glitch",    1, 3,  0, 0, 2'b00, 0,  0,  0, 25);
    do_reset(); run_case("btn_press",     1, 10, 0, 0, 2'b00, 0,  0,  0, 45);
    do_reset(); run_case("cancel12",      0, 0,  1, 0, 2'b10, 12, 0,  0, 40);
    do_reset(); run_case("cancel_final",  0, 0,  1, 0, 2'b01, 24, 0,  0, 40);
    do_reset(); run_case("req_btn_same",  1, 10, 1, 6, 2'b00, 0,  0,  0, 60);
    do_reset(); run_case("fire_ignore",   0, 0,  1, 0, 2'b10, 0,  0,  1, 70);
    do_reset(); run_case("rst_mid",       0, 0,  1, 0, 2'b01, 0,  15, 0, 40);
    do_reset(); run_case("rst_fire",      0, 0,  1, 0, 2'b00, 0,  30, 0, 40);

    for (int n = 0; n < 25; n++) begin
      kind = $urandom_range(0, 3);
      img  = 2'($urandom);
      canc = ($urandom % 2) ? $urandom_range(1, GRACE) : 0;
      do_reset();
      case (kind)
        0: run_case("rnd_req",     0, 0, 1, $urandom_range(0, 3), img, canc, 0, 1, 45);
        1: run_case("rnd_btn",     1, $urandom_range(1, 10), 0, 0, img, canc, 0, 1, 45);
        2: run_case("rnd_req_btn", 1, $urandom_range(6, 10), 1, 6, img, canc, 0, 0, 45);
        default: run_case("rnd_rst", 0, 0, 1, 0, img, 0, $urandom_range(1, 35), 0, 45);
      endcase
    end

    RST = 1'b1;
    repeat (2) @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
